// File: rtl/prf_free_list_pkg.sv
// Shared sizes and index types for the integer physical register free list.
package prf_free_list_pkg;

    localparam int PRF_INT_SIZE = 64;
    localparam int ARF_INT_SIZE = 32;
    localparam int RENAME_WIDTH = 2;
    localparam int COMMIT_WIDTH = 2;
    localparam int RAT_CP_SIZE  = 4;

    localparam int PRF_IDX_W = $clog2(PRF_INT_SIZE);
    localparam int FL_PTR_W  = PRF_IDX_W + 1;
    localparam int CP_IDX_W  = $clog2(RAT_CP_SIZE);

    typedef logic [PRF_IDX_W-1:0] prf_index_t;
    typedef logic [FL_PTR_W-1:0]  fl_ptr_t;
    typedef logic [CP_IDX_W-1:0]  cp_index_t;

endpackage

// File: rtl/prf_free_list_lane_rank.sv
// Per-lane prefix popcount of a request vector, plus the total count.
module lane_rank #(
    parameter int N = 2,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0]   req,
    output logic [N*W-1:0] rank,
    output logic [W-1:0]   total
);

    logic [W-1:0] acc;

    always_comb begin
        acc  = '0;
        rank = '0;
        for (int i = 0; i < N; i++) begin
            rank[i*W +: W] = acc;
            acc = acc + W'(req[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/prf_free_list.sv
// Circular free list of integer physical registers with per-branch head
// checkpoints for mispredict recovery.
module prf_free_list
    import prf_free_list_pkg::*;
#(
    parameter int PRF_SIZE     = PRF_INT_SIZE,
    parameter int ARF_SIZE     = ARF_INT_SIZE,
    parameter int RENAME_WIDTH = prf_free_list_pkg::RENAME_WIDTH,
    parameter int COMMIT_WIDTH = prf_free_list_pkg::COMMIT_WIDTH,
    parameter int CP_SIZE      = RAT_CP_SIZE
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      stall,
    input  logic [RENAME_WIDTH-1:0]                   alloc_req,
    output logic [RENAME_WIDTH*$clog2(PRF_SIZE)-1:0]  alloc_prf,
    output logic                                      allocatable,
    input  logic [COMMIT_WIDTH-1:0]                   release_req,
    input  logic [COMMIT_WIDTH*$clog2(PRF_SIZE)-1:0]  release_prf,
    input  logic                                      check,
    input  logic [RENAME_WIDTH-1:0]                   check_flag,
    input  logic [$clog2(CP_SIZE)-1:0]                check_idx,
    input  logic                                      recover,
    input  logic [$clog2(CP_SIZE)-1:0]                recover_idx,
    output logic [$clog2(PRF_SIZE):0]                 free_count
);

    localparam int IW = $clog2(PRF_SIZE);
    localparam int PW = IW + 1;
    localparam int AW = $clog2(RENAME_WIDTH + 1);
    localparam int RW = $clog2(COMMIT_WIDTH + 1);

    logic [IW-1:0] fifo [PRF_SIZE];
    logic [PW-1:0] cp   [CP_SIZE];
    logic [PW-1:0] head, tail;
    logic [PW-1:0] head_next, tail_next;
    logic [PW-1:0] cp_off;
    logic          fire;

    logic [RENAME_WIDTH*AW-1:0] alloc_rank;
    logic [AW-1:0]              alloc_total;
    logic [COMMIT_WIDTH-1:0]    rel_vld;
    logic [COMMIT_WIDTH*RW-1:0] rel_rank;
    logic [RW-1:0]              rel_total;
    logic [PW-1:0]              rd_ptr [RENAME_WIDTH];
    logic [PW-1:0]              wr_ptr [COMMIT_WIDTH];

    lane_rank #(.N(RENAME_WIDTH), .W(AW)) u_alloc_rank (
        .req   (alloc_req),
        .rank  (alloc_rank),
        .total (alloc_total)
    );

    lane_rank #(.N(COMMIT_WIDTH), .W(RW)) u_rel_rank (
        .req   (rel_vld),
        .rank  (rel_rank),
        .total (rel_total)
    );

    assign free_count  = tail - head;
    assign allocatable = free_count >= PW'(alloc_total);
    assign fire        = !stall && allocatable && !recover;

    always_comb begin
        alloc_prf = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            rd_ptr[i] = head + PW'(alloc_rank[i*AW +: AW]);
            if (alloc_req[i])
                alloc_prf[i*IW +: IW] = fifo[rd_ptr[i][IW-1:0]];
        end
    end

    // x0 is never a renamed destination, so retiring it frees nothing.
    always_comb begin
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            rel_vld[j] = release_req[j] &&
                         (release_prf[j*IW +: IW] != '0);
            wr_ptr[j]  = tail + PW'(rel_rank[j*RW +: RW]);
        end
    end

    // Offset of the first lane younger than the branch within this group.
    always_comb begin
        cp_off = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (check_flag[i])
                cp_off = PW'(alloc_rank[i*AW +: AW]) + PW'(alloc_req[i]);
        end
    end

    always_comb begin
        head_next = head;
        if (recover)
            head_next = cp[recover_idx];
        else if (fire)
            head_next = head + PW'(alloc_total);
        tail_next = tail + PW'(rel_total);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= PW'(PRF_SIZE - ARF_SIZE);
            for (int k = 0; k < PRF_SIZE; k++)
                fifo[k] <= (k < PRF_SIZE - ARF_SIZE) ? IW'(ARF_SIZE + k) : '0;
            for (int c = 0; c < CP_SIZE; c++)
                cp[c] <= '0;
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (fire && check)
                cp[check_idx] <= head + cp_off;
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (rel_vld[j])
                    fifo[wr_ptr[j][IW-1:0]] <= release_prf[j*IW +: IW];
            end
        end
    end

    logic [PW-1:0] free_next;
    assign free_next = tail_next - head_next;

    a_no_overfill: assert property (
        @(posedge clock) disable iff (!reset)
        free_next <= PW'(PRF_SIZE)
    );

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list against a sequence-number model.
module tb_prf_free_list;
    import prf_free_list_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [1:0]  alloc_req;
    logic [11:0] alloc_prf;
    logic        allocatable;
    logic [1:0]  release_req;
    logic [11:0] release_prf;
    logic        check;
    logic [1:0]  check_flag;
    logic [1:0]  check_idx;
    logic        recover;
    logic [1:0]  recover_idx;
    logic [6:0]  free_count;

    prf_free_list dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .alloc_req   (alloc_req),
        .alloc_prf   (alloc_prf),
        .allocatable (allocatable),
        .release_req (release_req),
        .release_prf (release_prf),
        .check       (check),
        .check_flag  (check_flag),
        .check_idx   (check_idx),
        .recover     (recover),
        .recover_idx (recover_idx),
        .free_count  (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: every index ever pushed gets an unbounded sequence number.
    int pushed [int];
    int push_seq;
    int alloc_seq;
    int cp_seq [4];
    bit live [int];

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        pushed.delete();
        live.delete();
        for (int k = 0; k < 32; k++) pushed[k] = 32 + k;
        push_seq  = 32;
        alloc_seq = 0;
        for (int c = 0; c < 4; c++) cp_seq[c] = 0;
    endfunction

    function automatic void model_compare();
        int fc, cnt, r;
        fc  = push_seq - alloc_seq;
        cnt = $countones(alloc_req);
        chk("free_count", 32'(free_count), fc);
        chk("allocatable", 32'(allocatable), 32'(fc >= cnt));
        r = 0;
        for (int i = 0; i < 2; i++) begin
            if (alloc_req[i]) begin
                if (r < fc)
                    chk("grant", 32'(alloc_prf[i*6 +: 6]),
                        pushed[alloc_seq + r]);
                r++;
            end else begin
                chk("grant_idle", 32'(alloc_prf[i*6 +: 6]), 0);
            end
        end
    endfunction

    function automatic void model_update();
        int fc, cnt, b, g;
        bit fire;
        fc   = push_seq - alloc_seq;
        cnt  = $countones(alloc_req);
        fire = !stall && (fc >= cnt) && !recover;
        for (int j = 0; j < 2; j++) begin
            if (release_req[j] && release_prf[j*6 +: 6] != 0) begin
                pushed[push_seq] = int'(release_prf[j*6 +: 6]);
                push_seq++;
                if (live.exists(int'(release_prf[j*6 +: 6])))
                    live.delete(int'(release_prf[j*6 +: 6]));
            end
        end
        if (recover) begin
            for (int s = cp_seq[recover_idx]; s < alloc_seq; s++)
                if (live.exists(pushed[s])) live.delete(pushed[s]);
            alloc_seq = cp_seq[recover_idx];
        end else if (fire) begin
            if (check) begin
                b = 0;
                for (int i = 0; i < 2; i++) if (check_flag[i]) b = i;
                cp_seq[check_idx] = alloc_seq +
                    $countones(alloc_req & 2'((2 << b) - 1));
            end
            for (int r = 0; r < cnt; r++) begin
                g = pushed[alloc_seq + r];
                chk("no_dup_grant", 32'(live.exists(g)), 0);
                live[g] = 1'b1;
            end
            alloc_seq += cnt;
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset) model_reset();
            model_compare();
            @(posedge clock);
            if (reset) model_update();
        end
    end

    task automatic idle();
        stall       = 1'b0;
        alloc_req   = '0;
        release_req = '0;
        release_prf = '0;
        check       = 1'b0;
        check_flag  = '0;
        check_idx   = '0;
        recover     = 1'b0;
        recover_idx = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pick_releases();
        int q[$];
        int a, b;
        release_req = '0;
        release_prf = '0;
        foreach (live[k]) q.push_back(k);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
            a = $urandom_range(0, q.size() - 1);
            release_req[0]   = 1'b1;
            release_prf[5:0] = 6'(q[a]);
            q.delete(a);
        end
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
            b = $urandom_range(0, q.size() - 1);
            release_req[1]    = 1'b1;
            release_prf[11:6] = 6'(q[b]);
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("rst_free_count", 32'(free_count), 32);
        chk("rst_allocatable", 32'(allocatable), 1);
        chk("rst_alloc_prf", 32'(alloc_prf), 0);

        alloc_req = 2'b11;
        #1;
        chk("t1_lane0", 32'(alloc_prf[5:0]), 32);
        chk("t1_lane1", 32'(alloc_prf[11:6]), 33);
        tick();
        alloc_req = 2'b00;
        #1 chk("t1_free", 32'(free_count), 30);

        alloc_req = 2'b10;
        #1;
        chk("t2_lane0", 32'(alloc_prf[5:0]), 0);
        chk("t2_lane1", 32'(alloc_prf[11:6]), 34);
        tick();
        alloc_req = 2'b00;
        #1 chk("t2_free", 32'(free_count), 29);

        alloc_req = 2'b11;
        repeat (14) tick();
        chk("t3_free1", 32'(free_count), 1);
        chk("t3_blocked", 32'(allocatable), 0);
        release_req = 2'b11;
        release_prf = {6'd0, 6'd5};
        #1 chk("t3_same_cycle", 32'(allocatable), 0);
        tick();
        release_req = '0;
        release_prf = '0;
        #1;
        chk("t3_free2", 32'(free_count), 2);
        chk("t3_allocatable", 32'(allocatable), 1);
        chk("t3_lane0", 32'(alloc_prf[5:0]), 63);
        chk("t3_lane1", 32'(alloc_prf[11:6]), 5);
        tick();
        alloc_req = 2'b01;
        #1;
        chk("t3_empty_free", 32'(free_count), 0);
        chk("t3_empty_alloc", 32'(allocatable), 0);
        alloc_req = 2'b00;

        for (int k = 0; k < 6; k++) begin
            release_req = 2'b11;
            release_prf = {6'(33 + 2*k), 6'(32 + 2*k)};
            tick();
        end
        release_req = '0;
        release_prf = '0;
        #1 chk("refill_free", 32'(free_count), 12);

        check      = 1'b1;
        check_flag = 2'b01;
        check_idx  = 2'd2;
        alloc_req  = 2'b11;
        #1;
        chk("t4_lane0", 32'(alloc_prf[5:0]), 32);
        chk("t4_lane1", 32'(alloc_prf[11:6]), 33);
        tick();
        check      = 1'b0;
        check_flag = '0;
        repeat (3) tick();
        alloc_req = 2'b00;
        #1 chk("t4_free", 32'(free_count), 4);
        recover     = 1'b1;
        recover_idx = 2'd2;
        alloc_req   = 2'b11;
        tick();
        recover   = 1'b0;
        alloc_req = 2'b01;
        #1;
        chk("t4_rec_free", 32'(free_count), 11);
        chk("t4_regrant", 32'(alloc_prf[5:0]), 33);

        alloc_req = 2'b11;
        tick();
        recover     = 1'b1;
        release_req = 2'b11;
        release_prf = {6'd45, 6'd44};
        tick();
        idle();
        alloc_req = 2'b01;
        #1;
        chk("t5_free", 32'(free_count), 13);
        chk("t5_regrant", 32'(alloc_prf[5:0]), 33);

        alloc_req = 2'b11;
        stall     = 1'b1;
        tick();
        stall = 1'b0;
        alloc_req = 2'b00;
        #1 chk("stall_hold", 32'(free_count), 13);

        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                #2;
                idle();
                reset = 1'b0;
                #1;
                chk("midrst_free", 32'(free_count), 32);
                chk("midrst_allocatable", 32'(allocatable), 1);
                chk("midrst_alloc_prf", 32'(alloc_prf), 0);
                tick();
                reset = 1'b1;
            end
            alloc_req = 2'($urandom_range(0, 3));
            stall     = ($urandom_range(0, 9) == 0);
            pick_releases();
            tick();
        end
        idle();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
